// File: rtl/frame_tx_streamer.sv
// Streams a frame (or rectangular window) out of a pixel frame buffer as a byte
// stream into a FIFO. An optional sync header and an XOR checksum trailer frame the payload.
module frame_tx_streamer #(
    parameter int IMG_WIDTH  = 176,
    parameter int IMG_HEIGHT = 240,
    parameter int PIX_BYTES  = 1,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT),
    parameter bit HDR_EN     = 1'b1,
    parameter bit CSUM_EN    = 1'b1,
    localparam int XW = $clog2(IMG_WIDTH+1),
    localparam int YW = $clog2(IMG_HEIGHT+1),
    localparam int DW = 8*PIX_BYTES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  roi_en,
    input  logic [XW-1:0]         roi_x0,
    input  logic [XW-1:0]         roi_w,
    input  logic [YW-1:0]         roi_y0,
    input  logic [YW-1:0]         roi_h,
    input  logic                  tx_full,
    output logic                  fb_re,
    output logic [ADDR_WIDTH-1:0] fb_rAddr,
    input  logic [DW-1:0]         fb_rData,
    output logic                  wr_en,
    output logic [7:0]            wr_data,
    output logic                  busy,
    output logic                  frame_tx_done,
    output logic                  cfg_err
);
    // state     | meaning
    // IDLE      | waiting for start
    // HDR       | writing sync bytes A5, 5A
    // READ_REQ  | one-cycle frame buffer read
    // READ_WAIT | capturing read data into the pixel register
    // SEND      | writing pixel byte lanes, LSB first
    // CSUM      | writing the XOR checksum trailer
    // DONE      | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE, HDR, READ_REQ, READ_WAIT, SEND, CSUM, DONE
    } state_t;

    localparam int LW = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(PIX_BYTES-1);

    state_t state_q, state_nxt;

    logic [XW-1:0]         x0_q, w_q, col_q;
    logic [YW-1:0]         h_q, row_q;
    logic [ADDR_WIDTH-1:0] row_base_q;
    logic [LW-1:0]         lane_q;
    logic                  hdr_idx_q;
    logic [7:0]            csum_q;
    logic [DW-1:0]         pix_q;

    logic [XW-1:0] x0_sel, w_sel;
    logic [YW-1:0] y0_sel, h_sel;
    logic          req_bad, start_req, start_ok;
    logic          lane_last, col_last, row_last;
    logic [7:0]    lane_byte;

    assign x0_sel = roi_en ? roi_x0 : '0;
    assign w_sel  = roi_en ? roi_w  : XW'(IMG_WIDTH);
    assign y0_sel = roi_en ? roi_y0 : '0;
    assign h_sel  = roi_en ? roi_h  : YW'(IMG_HEIGHT);

    // A full-frame request is always legal; only windows are range-checked.
    assign req_bad = roi_en && ((roi_w == '0) || (roi_h == '0) ||
                     ((32'(roi_x0) + 32'(roi_w)) > 32'(IMG_WIDTH)) ||
                     ((32'(roi_y0) + 32'(roi_h)) > 32'(IMG_HEIGHT)));

    assign start_req = (state_q == IDLE) && start && !abort;
    assign start_ok  = start_req && !req_bad;

    assign lane_last = (lane_q == LANE_LAST);
    assign col_last  = (col_q == w_q - XW'(1));
    assign row_last  = (row_q == h_q - YW'(1));
    assign busy      = (state_q != IDLE);

    always_comb begin
        lane_byte = '0;
        for (int k = 0; k < PIX_BYTES; k++) begin
            if (lane_q == LW'(k)) lane_byte = pix_q[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_nxt;
    end

    always_comb begin
        state_nxt     = state_q;
        fb_re         = 1'b0;
        fb_rAddr      = '0;
        wr_en         = 1'b0;
        wr_data       = '0;
        frame_tx_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) state_nxt = HDR_EN ? HDR : READ_REQ;
            end
            HDR: begin
                if (!tx_full) begin
                    wr_en   = 1'b1;
                    wr_data = hdr_idx_q ? 8'h5A : 8'hA5;
                    if (hdr_idx_q) state_nxt = READ_REQ;
                end
            end
            READ_REQ: begin
                fb_re     = 1'b1;
                fb_rAddr  = row_base_q + ADDR_WIDTH'(x0_q) + ADDR_WIDTH'(col_q);
                state_nxt = READ_WAIT;
            end
            READ_WAIT: state_nxt = SEND;
            SEND: begin
                if (!tx_full) begin
                    wr_en   = 1'b1;
                    wr_data = lane_byte;
                    if (lane_last) begin
                        if (col_last && row_last) state_nxt = CSUM_EN ? CSUM : DONE;
                        else                      state_nxt = READ_REQ;
                    end
                end
            end
            CSUM: begin
                if (!tx_full) begin
                    wr_en     = 1'b1;
                    wr_data   = csum_q;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_tx_done = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort silences every strobe in the cycle it is seen.
        if (abort && (state_q != IDLE)) begin
            state_nxt     = IDLE;
            fb_re         = 1'b0;
            fb_rAddr      = '0;
            wr_en         = 1'b0;
            wr_data       = '0;
            frame_tx_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            lane_q     <= '0;
            hdr_idx_q  <= 1'b0;
            csum_q     <= '0;
            pix_q      <= '0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= start_req && req_bad;
            if (start_ok) begin
                x0_q       <= x0_sel;
                w_q        <= w_sel;
                h_q        <= h_sel;
                col_q      <= '0;
                row_q      <= '0;
                row_base_q <= ADDR_WIDTH'(32'(y0_sel) * IMG_WIDTH);
                lane_q     <= '0;
                hdr_idx_q  <= 1'b0;
                csum_q     <= '0;
            end else if (!abort) begin
                case (state_q)
                    HDR:       if (wr_en) hdr_idx_q <= 1'b1;
                    READ_WAIT: pix_q <= fb_rData;
                    SEND: begin
                        if (wr_en) begin
                            csum_q <= csum_q ^ wr_data;
                            if (!lane_last) begin
                                lane_q <= lane_q + LW'(1);
                            end else begin
                                lane_q <= '0;
                                // Row base advances by the frame stride, avoiding a multiplier.
                                if (col_last) begin
                                    col_q      <= '0;
                                    row_q      <= row_q + YW'(1);
                                    row_base_q <= row_base_q + ADDR_WIDTH'(IMG_WIDTH);
                                end else begin
                                    col_q <= col_q + XW'(1);
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_tx_streamer.sv
// Scoreboard bench for frame_tx_streamer: a frame-level reference model queues expected
// bytes and read addresses, and a negedge monitor pops and compares them.
module tb_frame_tx_streamer;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PB = 2;
    localparam int AW = $clog2(W*H);
    localparam int BUDGET = 2000;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start, abort, roi_en, tx_full;
    logic [2:0]      roi_x0, roi_w;
    logic [1:0]      roi_y0, roi_h;
    logic            fb_re;
    logic [AW-1:0]   fb_rAddr;
    logic [8*PB-1:0] fb_rData;
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            busy, frame_tx_done, cfg_err;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int cfg_cnt = 0;
    int bp_mode = 0;
    logic force_full = 1'b0;

    logic [7:0] exp_bytes[$];
    int         exp_addr[$];

    frame_tx_streamer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_BYTES(PB),
        .HDR_EN(1'b1), .CSUM_EN(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .roi_en(roi_en), .roi_x0(roi_x0), .roi_w(roi_w),
        .roi_y0(roi_y0), .roi_h(roi_h), .tx_full(tx_full),
        .fb_re(fb_re), .fb_rAddr(fb_rAddr), .fb_rData(fb_rData),
        .wr_en(wr_en), .wr_data(wr_data), .busy(busy),
        .frame_tx_done(frame_tx_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Frame buffer: mem[a] = 16'h0101 * a, one cycle read latency.
    always @(posedge clk) begin
        if (fb_re) fb_rData <= 16'(32'h0101 * 32'(fb_rAddr));
    end

    // Sole driver of tx_full: random backpressure or a level forced by the main sequence.
    initial begin
        tx_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 1) tx_full = ($urandom_range(0, 2) == 0);
            else              tx_full = force_full;
            #0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            chk("wr_en_while_full", int'(tx_full), 0);
            if (exp_bytes.size() == 0) begin
                chk("unexpected_write", int'(wr_data), -1);
            end else begin
                chk("wr_data", int'(wr_data), int'(exp_bytes.pop_front()));
            end
        end else begin
            chk("wr_data_idle_zero", int'(wr_data), 0);
        end
        if (fb_re) begin
            if (exp_addr.size() == 0) chk("unexpected_read", int'(fb_rAddr), -1);
            else                      chk("fb_rAddr", int'(fb_rAddr), exp_addr.pop_front());
        end else begin
            chk("fb_rAddr_idle_zero", int'(fb_rAddr), 0);
        end
        if (frame_tx_done) done_cnt++;
        if (cfg_err) cfg_cnt++;
    end

    task automatic model_frame(input bit re, input int x0, input int y0, input int w, input int h);
        logic [7:0]  cs;
        logic [31:0] word;
        if (!re) begin
            x0 = 0; y0 = 0; w = W; h = H;
        end
        cs = 8'h00;
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(8'h5A);
        for (int y = y0; y < y0 + h; y++) begin
            for (int x = x0; x < x0 + w; x++) begin
                exp_addr.push_back(y*W + x);
                word = 32'h0101 * (y*W + x);
                for (int k = 0; k < PB; k++) begin
                    exp_bytes.push_back(word[8*k +: 8]);
                    cs = cs ^ word[8*k +: 8];
                end
            end
        end
        exp_bytes.push_back(cs);
    endtask

    task automatic set_req(input bit re, input int x0, input int y0, input int w, input int h);
        roi_en = re;
        roi_x0 = 3'(x0);
        roi_y0 = 2'(y0);
        roi_w  = 3'(w);
        roi_h  = 2'(h);
    endtask

    task automatic issue_start(input bit re, input int x0, input int y0, input int w, input int h);
        set_req(re, x0, y0, w, h);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_frame(input bit spam, input int d0);
        bit found = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            if (frame_tx_done) begin
                found = 1'b1;
                start = 1'b0;
                break;
            end
            start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("done_seen", int'(found), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("done_count", done_cnt, d0 + 1);
        chk("bytes_left", exp_bytes.size(), 0);
        chk("reads_left", exp_addr.size(), 0);
        chk("busy_after_done", int'(busy), 0);
    endtask

    task automatic run_frame(input bit re, input int x0, input int y0, input int w, input int h,
                             input bit spam);
        int d0 = done_cnt;
        model_frame(re, x0, y0, w, h);
        issue_start(re, x0, y0, w, h);
        finish_frame(spam, d0);
    endtask

    task automatic wait_addr(input int a);
        bit found = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            if (fb_re && int'(fb_rAddr) == a) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("read_addr_seen", int'(found), 1);
    endtask

    initial begin
        int d0, c0, x0, y0, w, h;
        reset_n = 1'b0;
        start = 1'b0; abort = 1'b0;
        set_req(1'b0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_fb_re", int'(fb_re), 0);
        chk("rst_done", int'(frame_tx_done), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_frame(1'b0, 0, 0, 0, 0, 1'b0);
        run_frame(1'b1, 1, 1, 2, 2, 1'b0);

        // Backpressure for 7 cycles starting at the first SEND cycle of pixel 2.
        d0 = done_cnt;
        model_frame(1'b0, 0, 0, 0, 0);
        issue_start(1'b0, 0, 0, 0, 0);
        wait_addr(2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        force_full = 1'b1;
        #1;
        for (int i = 0; i < 7; i++) begin
            chk("bp_wr_en_held", int'(wr_en), 0);
            @(posedge clk); #2;
        end
        force_full = 1'b0;
        finish_frame(1'b0, d0);

        // Abort in SEND of pixel 3, then a clean full frame.
        d0 = done_cnt;
        model_frame(1'b0, 0, 0, 0, 0);
        issue_start(1'b0, 0, 0, 0, 0);
        wait_addr(3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        #1;
        chk("abort_wr_en", int'(wr_en), 0);
        chk("abort_done", int'(frame_tx_done), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        exp_bytes.delete();
        exp_addr.delete();
        @(posedge clk); #1;
        chk("abort_no_done", done_cnt, d0);
        run_frame(1'b0, 0, 0, 0, 0, 1'b0);

        // Abort while idle changes nothing; abort beats a simultaneous start.
        abort = 1'b1;
        issue_start(1'b0, 0, 0, 0, 0);
        abort = 1'b0;
        chk("abort_over_start_busy", int'(busy), 0);

        // Rejected windows.
        c0 = cfg_cnt;
        issue_start(1'b1, 3, 0, 2, 1);
        chk("bad_x_cfg_err", int'(cfg_err), 1);
        chk("bad_x_busy", int'(busy), 0);
        @(posedge clk); #1;
        chk("bad_x_cfg_err_pulse", int'(cfg_err), 0);
        chk("bad_x_cfg_count", cfg_cnt, c0 + 1);
        issue_start(1'b1, 0, 0, 0, 2);
        chk("bad_w0_cfg_err", int'(cfg_err), 1);
        issue_start(1'b1, 0, 2, 1, 2);
        chk("bad_y_cfg_err", int'(cfg_err), 1);
        @(posedge clk); #1;
        chk("bad_busy_stays_0", int'(busy), 0);
        chk("bad_cfg_count", cfg_cnt, c0 + 3);

        // Reset mid-SEND, then start taken on the first edge after release.
        d0 = done_cnt;
        model_frame(1'b0, 0, 0, 0, 0);
        issue_start(1'b0, 0, 0, 0, 0);
        wait_addr(4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_wr_en", int'(wr_en), 0);
        chk("rstmid_wr_data", int'(wr_data), 0);
        chk("rstmid_fb_re", int'(fb_re), 0);
        chk("rstmid_done", int'(frame_tx_done), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_bytes.delete();
        exp_addr.delete();
        chk("rstmid_no_done", done_cnt, d0);
        model_frame(1'b0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        set_req(1'b0, 0, 0, 0, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_first_edge_busy", int'(busy), 1);
        finish_frame(1'b0, d0);

        // Start pulses while busy are ignored.
        run_frame(1'b0, 0, 0, 0, 0, 1'b1);

        // Random legal windows under random backpressure.
        bp_mode = 1;
        for (int i = 0; i < 10; i++) begin
            x0 = $urandom_range(0, W-1);
            w  = $urandom_range(1, W - x0);
            y0 = $urandom_range(0, H-1);
            h  = $urandom_range(1, H - y0);
            run_frame(1'b1, x0, y0, w, h, 1'($urandom_range(0, 1)));
        end
        bp_mode = 0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
